lc3_mem_access: RTL and testbench
=================================

Name: lc3_mem_access

Overview:
- Memory-access stage of the LC3 pipeline; sits directly downstream of Execute.
- Consumes the executed instruction's opcode, effective address and store data, and performs LD/LDR/LDI/ST/STR/STI on the data-memory port using a ready handshake.
- Returns load data to Writeback.
- Drives busy so the controller can deassert the upstream pipeline enables while an access is in flight.

Parameters:
- WIDTH, 16, data and address width.
- MAX_WAIT, 15, maximum cycles a memory state waits for dmem_ready before abort; counter width is clog2(MAX_WAIT+1).

Ports:
- clock  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  Execute result valid; launch access this cycle if idle
- opcode  in  4  IR_Exec[15:12] of the executed instruction
- eff_addr  in  WIDTH  effective address (Execute pcout)
- st_data  in  WIDTH  store data (Execute M_Data)
- dmem_addr  out  WIDTH  memory address
- dmem_wdata  out  WIDTH  memory write data
- dmem_rd  out  1  read request
- dmem_we  out  1  write request
- dmem_rdata  in  WIDTH  memory read data, valid when dmem_ready=1
- dmem_ready  in  1  access completes at this edge
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, access finished
- load_valid  out  1  one-cycle pulse with done for LD/LDR/LDI
- memout  out  WIDTH  last loaded value, held until next load
- err  out  1  one-cycle pulse with done on timeout

Behaviour:
- Reset: state=IDLE, all outputs 0, internal address/data/opcode registers and wait counter 0. Reset mid-access abandons the access; no done pulse.
- States: IDLE, IND, READ, WRITE. All outputs are registered or decoded from state registers only; no combinational path from inputs to outputs.
- IDLE:
  - If start=1 and opcode is in {0010,0110,1010,0011,0111,1011}, latch eff_addr, st_data and opcode.
  - Next state: IND for 1010/1011; READ for 0010/0110; WRITE for 0011/0111.
  - Any other opcode with start=1: no action, stay IDLE, no done.
- start while busy=1 is ignored; upstream must hold the instruction.
- IND:
  - dmem_rd=1, dmem_addr=latched address.
  - On ready, the latched address is replaced by dmem_rdata, then go to READ (LDI) or WRITE (STI).
- READ:
  - dmem_rd=1.
  - On ready: memout<=dmem_rdata, done=1 and load_valid=1 next cycle, go to IDLE.
- WRITE:
  - dmem_we=1, dmem_wdata=latched st_data.
  - On ready: done=1 next cycle, go to IDLE.
- dmem_rd and dmem_we are never both 1. Both are 0 in IDLE. dmem_addr and dmem_wdata are 0 in IDLE.
- Latency with ready held high: LD/ST take 2 cycles from start to done; LDI/STI take 3.
- Back-to-back: a start in the cycle the FSM is back in IDLE (the same cycle done is high) is accepted.
- Wait counter:
  - Cleared on entry to every memory state; increments each cycle in that state without ready.
  - If ready is not seen and the counter equals MAX_WAIT: go to IDLE, done=1, err=1, load_valid=0, memout unchanged, no write-back.
  - Ready arriving on the same edge as the limit takes priority over timeout.

Optional Feature:
- LC3_MEM_PERF_EN defined: adds output port stall_cycles [15:0], which counts cycles with busy=1 and dmem_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset only.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- LD: start, opcode=0010, eff_addr=16'h3000, memory returns 16'hBEEF with ready always 1 -> dmem_rd high 1 cycle at addr 3000; done=load_valid=1 two cycles after start; memout=BEEF.
- STI: opcode=1011, eff_addr=16'h3010, st_data=16'h1234, mem[3010]=16'h4000 -> read at 3010, then dmem_we=1 at addr 4000 with wdata 1234; done three cycles after start; load_valid=0.
- Wait states: LDR at 16'h0050, ready withheld 4 cycles, data 16'h00AA -> dmem_rd and addr stable throughout; done in the cycle after ready; busy high for 5 cycles.
- Timeout: MAX_WAIT=15, ST, ready never asserted -> WRITE lasts 16 cycles, then done=err=1 for 1 cycle; return to IDLE.
- Non-memory and busy cases: opcode=0001 with start=1 -> no request, busy stays 0. A start arriving during an LDI is ignored.
- Reset during READ with ready=0 -> next cycle busy=0, dmem_rd=0, done=0, memout=0. With LC3_MEM_PERF_EN, stall_cycles=0.

Source files
------------

// File: rtl/lc3_mem_access.sv
// LC3 memory-access stage: LD/LDR/LDI/ST/STR/STI over a ready-handshake data port.
// Optional LC3_MEM_PERF_EN adds a saturating stall_cycles counter output.
module lc3_mem_access #(
  parameter int WIDTH    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] eff_addr,
  input  logic [WIDTH-1:0] st_data,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic             dmem_rd,
  output logic             dmem_we,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ready,
  output logic             busy,
  output logic             done,
  output logic             load_valid,
  output logic [WIDTH-1:0] memout,
`ifdef LC3_MEM_PERF_EN
  output logic [15:0]      stall_cycles,
`endif
  output logic             err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, IND, READ, WRITE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] addr_q, data_q;
  logic [3:0]       op_q;
  logic [CW-1:0]    wait_q;
  logic             accept, timeout;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (opcode)
            4'b1010, 4'b1011: begin accept = 1'b1; state_next = IND;   end
            4'b0010, 4'b0110: begin accept = 1'b1; state_next = READ;  end
            4'b0011, 4'b0111: begin accept = 1'b1; state_next = WRITE; end
            default: ;
          endcase
        end
      end
      IND: begin
        if (dmem_ready)
          state_next = (op_q == 4'b1011) ? WRITE : READ;
        else if (wait_q == CW'(MAX_WAIT)) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      READ, WRITE: begin
        if (dmem_ready)
          state_next = IDLE;
        else if (wait_q == CW'(MAX_WAIT)) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      op_q       <= '0;
      wait_q     <= '0;
      memout     <= '0;
      done       <= 1'b0;
      load_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      done       <= 1'b0;
      load_valid <= 1'b0;
      err        <= 1'b0;

      if (accept) begin
        addr_q <= eff_addr;
        data_q <= st_data;
        op_q   <= opcode;
      end

      // Any state change is an entry into a fresh phase (or a return to IDLE).
      if (state_next != state)
        wait_q <= '0;
      else if (state != IDLE)
        wait_q <= wait_q + 1'b1;

      if (dmem_ready) begin
        case (state)
          IND:  addr_q <= dmem_rdata;
          READ: begin
            memout     <= dmem_rdata;
            done       <= 1'b1;
            load_valid <= 1'b1;
          end
          WRITE: done <= 1'b1;
          default: ;
        endcase
      end else if (timeout) begin
        done <= 1'b1;
        err  <= 1'b1;
      end
    end
  end

  assign busy       = (state != IDLE);
  assign dmem_rd    = (state == IND) || (state == READ);
  assign dmem_we    = (state == WRITE);
  assign dmem_addr  = busy    ? addr_q : '0;
  assign dmem_wdata = dmem_we ? data_q : '0;

`ifdef LC3_MEM_PERF_EN
  always_ff @(posedge clock) begin
    if (reset)
      stall_cycles <= '0;
    else if (busy && !dmem_ready && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lc3_mem_access.sv
// Scoreboard bench for lc3_mem_access with a behavioural data memory and ready control.
module tb_lc3_mem_access;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [3:0]  opcode;
  logic [15:0] eff_addr, st_data, dmem_addr, dmem_wdata, dmem_rdata, memout;
  logic        dmem_rd, dmem_we, dmem_ready, busy, done, load_valid, err;
`ifdef LC3_MEM_PERF_EN
  logic [15:0] stall_cycles;
`endif

  always #5 clock = ~clock;

  lc3_mem_access #(.WIDTH(16), .MAX_WAIT(15)) dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode),
    .eff_addr(eff_addr), .st_data(st_data),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rd(dmem_rd), .dmem_we(dmem_we),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .busy(busy), .done(done), .load_valid(load_valid), .memout(memout),
`ifdef LC3_MEM_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        lv;
    logic        er;
    logic [15:0] mo;
  } exp_t;
  exp_t sb[$];

  // Behavioural memory: ready after ready_wait cycles in each phase, or never.
  logic [15:0] mem [0:8191];
  logic        pre_we = 1'b0;
  logic [12:0] pre_a;
  logic [15:0] pre_d;
  int          ready_wait = 0;
  bit          never_ready = 1'b0;
  int          wcnt = 0;
  int          wr_count = 0;
  logic [15:0] last_wa = '0, last_wd = '0;

  always_comb dmem_ready = (dmem_rd || dmem_we) && !never_ready && (wcnt >= ready_wait);
  always_comb dmem_rdata = dmem_ready ? mem[dmem_addr[12:0]] : 16'hDEAD;

  always @(posedge clock) begin
    if (!(dmem_rd || dmem_we) || dmem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (pre_we) mem[pre_a] <= pre_d;
    else if (dmem_we && dmem_ready) begin
      mem[dmem_addr[12:0]] <= dmem_wdata;
      wr_count <= wr_count + 1;
      last_wa  <= dmem_addr;
      last_wd  <= dmem_wdata;
    end
  end

  int stall_model = 0;
  always @(posedge clock) begin
    if (reset) stall_model <= 0;
    else if (busy && !dmem_ready && stall_model < 65535) stall_model <= stall_model + 1;
  end

  int excl_viol = 0, idle_viol = 0, pulse_viol = 0;
  always @(negedge clock) begin
    if (!reset) begin
      if (dmem_rd && dmem_we) excl_viol++;
      if (!busy && (dmem_rd || dmem_we || dmem_addr != 16'h0 || dmem_wdata != 16'h0)) idle_viol++;
      if (!done && (load_valid || err)) pulse_viol++;
      if (done) begin : pop
        exp_t e;
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("load_valid", load_valid, e.lv);
          check("err", err, e.er);
          check("memout", memout, e.mo);
        end
      end
    end
  end

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_a  = a[12:0];
    pre_d  = d;
    pre_we = 1'b1;
    @(posedge clock);
    #1 pre_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] d,
                       input logic lv, input logic er, input logic [15:0] mo);
    sb.push_back('{lv: lv, er: er, mo: mo});
    opcode   = op;
    eff_addr = a;
    st_data  = d;
    start    = 1'b1;
  endtask

  logic [15:0] rd_q[$];

  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy, input bit intrude);
    int n  = 0;
    int nb = 0;
    bit seen = 1'b0;
    rd_q.delete();
    @(posedge clock);
    while (!seen && n < 100) begin
      @(negedge clock);
      n++;
      if (n == 1) start = 1'b0;
      if (intrude && n == 1) begin
        start = 1'b1; opcode = 4'b0010; eff_addr = 16'h0050;
      end
      if (intrude && n == 3) start = 1'b0;
      if (busy) nb++;
      if (dmem_rd) rd_q.push_back(dmem_addr);
      seen = done;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_busy_cycles"}, nb, exp_busy);
  endtask

  initial begin
    int w0, cnt;
    reset = 1'b1; start = 1'b0; opcode = '0; eff_addr = '0; st_data = '0;
    preload(16'h3000, 16'hBEEF);
    preload(16'h3010, 16'h4000);
    preload(16'h0050, 16'h00AA);
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_rd_we", {dmem_rd, dmem_we}, 0);
    check("rst_pulses", {done, load_valid, err}, 0);
    check("rst_memout", memout, 0);
    check("rst_addr", dmem_addr, 0);
    reset = 1'b0;

    // LD
    issue(4'b0010, 16'h3000, 16'h0, 1, 0, 16'hBEEF);
    wait_done("ld", 2, 1, 0);
    check("ld_rd_count", rd_q.size(), 1);
    if (rd_q.size() > 0) check("ld_rd_addr", rd_q[0], 16'h3000);

    // STI through pointer at 3010
    w0 = wr_count;
    issue(4'b1011, 16'h3010, 16'h1234, 0, 0, 16'hBEEF);
    wait_done("sti", 3, 2, 0);
    check("sti_rd_count", rd_q.size(), 1);
    if (rd_q.size() > 0) check("sti_rd_addr", rd_q[0], 16'h3010);
    check("sti_wr_count", wr_count - w0, 1);
    check("sti_wr_addr", last_wa, 16'h4000);
    check("sti_wr_data", last_wd, 16'h1234);

    // LDR with four wait states
    ready_wait = 4;
    issue(4'b0110, 16'h0050, 16'h0, 1, 0, 16'h00AA);
    wait_done("ldr_wait", 6, 5, 0);
    ready_wait = 0;
    check("ldr_rd_cycles", rd_q.size(), 5);
    cnt = 0;
    foreach (rd_q[i]) if (rd_q[i] != 16'h0050) cnt++;
    check("ldr_addr_stable", cnt, 0);

    // Back-to-back: second start lands in the done cycle
    issue(4'b0010, 16'h3000, 16'h0, 1, 0, 16'hBEEF);
    wait_done("b2b_ld", 2, 1, 0);
    issue(4'b0111, 16'h0060, 16'h7777, 0, 0, 16'hBEEF);
    wait_done("b2b_st", 2, 1, 0);
    check("b2b_wr_addr", last_wa, 16'h0060);
    check("b2b_wr_data", last_wd, 16'h7777);

    // LDI with an intruding start held during IND/READ
    issue(4'b1010, 16'h3010, 16'h0, 1, 0, 16'h1234);
    wait_done("ldi_intr", 3, 2, 1);
    cnt = 0;
    repeat (3) begin
      @(negedge clock);
      if (busy || dmem_rd) cnt++;
    end
    check("ldi_intr_ignored", cnt, 0);

    // Non-memory opcode
    opcode = 4'b0001; eff_addr = 16'h3000; start = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clock);
      start = 1'b0;
      if (busy || dmem_rd || dmem_we) cnt++;
    end
    check("nonmem_idle", cnt, 0);

    // ST timeout
    never_ready = 1'b1;
    w0 = wr_count;
    issue(4'b0011, 16'h3020, 16'h5555, 0, 1, 16'h1234);
    wait_done("st_timeout", 17, 16, 0);
    check("to_no_write", wr_count - w0, 0);
    @(negedge clock);
    check("to_done_pulse", done, 0);
    check("to_idle", busy, 0);

    // Reset while READ waits
    opcode = 4'b0010; eff_addr = 16'h3000; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("pre_rst_busy", busy, 1);
`ifdef LC3_MEM_PERF_EN
    check("stall_count", stall_cycles, stall_model);
`endif
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd", dmem_rd, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_memout", memout, 0);
`ifdef LC3_MEM_PERF_EN
    check("mid_rst_stall", stall_cycles, 0);
`endif
    reset = 1'b0;
    never_ready = 1'b0;
    repeat (2) @(negedge clock);

    check("rd_we_exclusive", excl_viol, 0);
    check("idle_outputs_zero", idle_viol, 0);
    check("pulses_with_done", pulse_viol, 0);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
